mem_port_arbiter: RTL and testbench

//   Shares the single backing-memory port between the instruction-cache refill

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one backing-memory port between the I-cache
// refill engine and the D-cache refill/writeback engine. One owner at a time,
// fixed-length line bursts, D-over-I priority with a starvation guard that
// forces an I grant after STARVE_MAX consecutive D grants made while I waited.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int LB = BW + 2;
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic [ADDR_W-LB-1:0] base_q, base_d;
    logic                we_q, we_d;
    logic                owner_d_q, owner_d_d;   // 1 = current/last burst belongs to D
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;

    logic busy;
    logic wr_burst;
    logic unused_addr_bits;

    // Line-offset bits of the request addresses are ignored by design.
    assign unused_addr_bits = ^{i_addr[LB-1:0], d_addr[LB-1:0]};

    assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign wr_burst  = (state_q == BUSY_D) && we_q;

    assign mem_req   = busy;
    assign mem_we    = wr_burst;
    assign mem_addr  = {base_q, beat_q, 2'b00};
    assign mem_wdata = wr_burst ? d_wdata : '0;
    assign d_wready  = wr_burst && mem_ack;
    assign i_done    = (state_q == RELEASE) && !owner_d_q;
    assign d_done    = (state_q == RELEASE) && owner_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;

    // State registers; an asserted reset drops everything back to idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            streak_q   <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            owner_d_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            streak_q   <= streak_d;
            base_q     <= base_d;
            we_q       <= we_d;
            owner_d_q  <= owner_d_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    // Arbitration, beat sequencing and read-data capture.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        streak_d   = streak_q;
        base_d     = base_q;
        we_d       = we_q;
        owner_d_d  = owner_d_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // D wins a tie unless it has already starved I for STARVE_MAX grants.
                if (d_req && (!i_req || (streak_q != STARVE_LIM))) begin
                    state_d   = BUSY_D;
                    base_d    = d_addr[ADDR_W-1:LB];
                    we_d      = d_we;
                    owner_d_d = 1'b1;
                    beat_d    = '0;
                    if (i_req && (streak_q < STARVE_LIM)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (i_req) begin
                    state_d   = BUSY_I;
                    base_d    = i_addr[ADDR_W-1:LB];
                    we_d      = 1'b0;
                    owner_d_d = 1'b0;
                    beat_d    = '0;
                    streak_d  = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    if (!wr_burst) begin
                        if (state_q == BUSY_D) begin
                            d_rdata_d  = mem_rdata;
                            d_rvalid_d = 1'b1;
                        end else begin
                            i_rdata_d  = mem_rdata;
                            i_rvalid_d = 1'b1;
                        end
                    end
                    // The beat counter parks on the last beat rather than wrapping.
                    if (beat_q == LAST_BEAT) begin
                        state_d = RELEASE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BL     = 4;
    localparam int SMAX   = 2;

    logic clk = 1'b0;
    logic reset;
    logic i_req, d_req, d_we, d_wready, mem_ack;
    logic [ADDR_W-1:0] i_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %0s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %0s: event seen, required none", name);
    endtask

    // ---------------- reference model / scoreboard queues ----------------
    typedef struct packed { logic [31:0] addr; logic we; } beat_t;
    typedef struct packed { int cyc; logic [31:0] data; } rd_t;

    beat_t beat_q[$];
    rd_t   i_rd_q[$], d_rd_q[$];
    int    i_done_q[$], d_done_q[$];
    logic  obs_grant[$];

    int          m_cyc = 0;
    int          m_state = 0;     // 0 free, 1 burst in progress, 2 release cycle
    int          m_left, m_streak = 0;
    logic        m_owner_d, m_we, gd, gi;
    logic [31:0] m_addr, m_base;
    beat_t       m_beat;
    rd_t         m_rd;

    // Model: arbitration rule + burst bookkeeping, evaluated on each clock edge.
    initial begin
        forever begin
            @(posedge clk);
            m_cyc++;
            if (reset) begin
                m_state = 0; m_streak = 0;
                beat_q.delete(); i_rd_q.delete(); d_rd_q.delete();
                i_done_q.delete(); d_done_q.delete();
                continue;
            end
            case (m_state)
                0: begin
                    gd = d_req && (!i_req || m_streak != SMAX);
                    gi = !gd && i_req;
                    if (gd || gi) begin
                        m_owner_d = gd;
                        m_addr    = gd ? d_addr : i_addr;
                        m_we      = gd && d_we;
                        if (gd && i_req && m_streak < SMAX) m_streak++;
                        if (gi) m_streak = 0;
                        m_base = m_addr & ~(32'(BL * 4 - 1));
                        for (int b = 0; b < BL; b++) begin
                            m_beat.addr = m_base + 32'(4 * b);
                            m_beat.we   = m_we;
                            beat_q.push_back(m_beat);
                        end
                        m_left  = BL;
                        m_state = 1;
                    end
                end
                1: if (mem_ack) begin
                    if (!m_we) begin
                        m_rd.cyc = m_cyc; m_rd.data = mem_rdata;
                        if (m_owner_d) d_rd_q.push_back(m_rd); else i_rd_q.push_back(m_rd);
                    end
                    m_left--;
                    if (m_left == 0) begin
                        if (m_owner_d) d_done_q.push_back(m_cyc); else i_done_q.push_back(m_cyc);
                        m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    logic  prev_req = 1'b0;
    beat_t mon_b;
    rd_t   mon_r;
    int    mon_c;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin prev_req = 1'b0; continue; end
            chk("mem_req", mem_req, (m_state == 1));
            chk("d_wready", d_wready, (m_state == 1) && m_owner_d && m_we && mem_ack);
            if (mem_req && !prev_req) obs_grant.push_back(mem_addr[31]);
            prev_req = mem_req;
            if (mem_req && mem_ack) begin
                if (beat_q.size() == 0) fail_evt("unexpected beat");
                else begin
                    mon_b = beat_q.pop_front();
                    chk("mem_addr", mem_addr, mon_b.addr);
                    chk("mem_we", mem_we, mon_b.we);
                    if (mon_b.we) chk("mem_wdata", mem_wdata, d_wdata);
                end
            end
            if (i_rvalid) begin
                if (i_rd_q.size() == 0) fail_evt("unexpected i_rvalid");
                else begin
                    mon_r = i_rd_q.pop_front();
                    chk("i_rdata", i_rdata, mon_r.data);
                    chk("i_rvalid cycle", m_cyc, mon_r.cyc);
                end
            end else if (i_rd_q.size() > 0 && i_rd_q[0].cyc <= m_cyc) begin
                void'(i_rd_q.pop_front()); fail_evt("missing i_rvalid");
            end
            if (d_rvalid) begin
                if (d_rd_q.size() == 0) fail_evt("unexpected d_rvalid");
                else begin
                    mon_r = d_rd_q.pop_front();
                    chk("d_rdata", d_rdata, mon_r.data);
                    chk("d_rvalid cycle", m_cyc, mon_r.cyc);
                end
            end else if (d_rd_q.size() > 0 && d_rd_q[0].cyc <= m_cyc) begin
                void'(d_rd_q.pop_front()); fail_evt("missing d_rvalid");
            end
            if (i_done) begin
                if (i_done_q.size() == 0) fail_evt("unexpected i_done");
                else begin
                    mon_c = i_done_q.pop_front();
                    chk("i_done cycle", m_cyc, mon_c);
                    $display("txn I burst done, cycle %0d", m_cyc);
                end
            end else if (i_done_q.size() > 0 && i_done_q[0] <= m_cyc) begin
                void'(i_done_q.pop_front()); fail_evt("missing i_done");
            end
            if (d_done) begin
                if (d_done_q.size() == 0) fail_evt("unexpected d_done");
                else begin
                    mon_c = d_done_q.pop_front();
                    chk("d_done cycle", m_cyc, mon_c);
                    $display("txn D burst done, cycle %0d", m_cyc);
                end
            end else if (d_done_q.size() > 0 && d_done_q[0] <= m_cyc) begin
                void'(d_done_q.pop_front()); fail_evt("missing d_done");
            end
        end
    end

    // Memory responder.
    int ack_mode = 0;   // 0 every cycle, 1 every 3rd cycle, 2 random
    int ack_cnt  = 0;
    initial begin
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #3;
            ack_cnt++;
            case (ack_mode)
                0: mem_ack = 1'b1;
                1: mem_ack = (ack_cnt % 3 == 0);
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
            mem_rdata = $urandom;
        end
    end

    // D-side write data source: presents the next word after each d_wready.
    initial begin
        logic adv;
        d_wdata = $urandom | 32'h1;
        forever begin
            @(negedge clk); adv = d_wready;
            @(posedge clk); #3;
            if (adv) d_wdata = $urandom | 32'h1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_i_done();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (i_done) break;
        end
        if (k == 400) fail_evt("i_done timeout");
        i_req = 1'b0;
    endtask

    task automatic wait_d_done();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (d_done) break;
        end
        if (k == 400) fail_evt("d_done timeout");
        d_req = 1'b0;
    endtask

    task automatic run_i(input logic [31:0] addr);
        @(negedge clk); i_addr = addr; i_req = 1'b1;
        wait_i_done();
    endtask

    task automatic run_d(input logic [31:0] addr, input logic we);
        @(negedge clk); d_addr = addr; d_we = we; d_req = 1'b1;
        wait_d_done();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " i_rdata"}, i_rdata, 0);   chk({tag, " i_rvalid"}, i_rvalid, 0);
        chk({tag, " i_done"}, i_done, 0);     chk({tag, " d_wready"}, d_wready, 0);
        chk({tag, " d_rdata"}, d_rdata, 0);   chk({tag, " d_rvalid"}, d_rvalid, 0);
        chk({tag, " d_done"}, d_done, 0);     chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_we"}, mem_we, 0);     chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
    endtask

    logic exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int k;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; reset = 0;
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(posedge clk); #3 reset = 0;

        // I-only line read, ack every cycle
        ack_mode = 0;
        run_i(32'h0000_1234);

        // D line write, ack every third cycle
        ack_mode = 1;
        run_d(32'h0000_0080, 1'b1);

        // Both requesters held: grant order D, D, I, D, D, I
        ack_mode = 0;
        obs_grant.delete();
        fork
            begin repeat (2) run_i(32'h0000_1000); end
            begin repeat (4) run_d(32'h8000_0000, 1'b0); end
        join
        chk("grant count", obs_grant.size(), 6);
        for (int g = 0; g < 6 && g < obs_grant.size(); g++)
            chk($sformatf("grant %0d is D", g), obs_grant[g], exp_order[g]);

        // d_req rising in the RELEASE cycle of an I burst
        @(negedge clk); i_addr = 32'h0000_2040; i_req = 1'b1;
        wait_i_done();
        d_addr = 32'h8000_0100; d_we = 1'b0; d_req = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!mem_req && k < 20);
        chk("D grant delay after release", k, 2);
        wait_d_done();

        // Reset during beat 2 of a D read
        @(negedge clk); d_addr = 32'h8000_0300; d_we = 1'b0; d_req = 1'b1;
        k = 0;
        do begin @(negedge clk); #1; k++; end while (beat_q.size() != BL - 2 && k < 50);
        chk("reached beat 2", (k < 50), 1);
        @(posedge clk); #2;
        reset = 1; d_req = 1'b0;
        #1 check_zero("mid-burst reset");
        repeat (2) @(posedge clk);
        #3 reset = 0;
        run_d(32'h8000_0300, 1'b0);

        // Spurious acks while idle
        ack_mode = 0;
        repeat (6) begin
            @(negedge clk);
            chk("idle i_rvalid", i_rvalid, 0);
            chk("idle d_rvalid", d_rvalid, 0);
            chk("idle mem_req", mem_req, 0);
        end

        // Randomized traffic with random memory latency
        ack_mode = 2;
        fork
            begin
                for (int t = 0; t < 20; t++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    run_i({1'b0, 31'($urandom)});
                end
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    run_d($urandom, 1'($urandom_range(0, 1)));
                end
            end
        join

        repeat (4) @(negedge clk);
        chk("beats left over", beat_q.size(), 0);
        chk("i reads left over", i_rd_q.size(), 0);
        chk("d reads left over", d_rd_q.size(), 0);
        chk("i done left over", i_done_q.size(), 0);
        chk("d done left over", d_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
